// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode, state, sel bit-map and ALUop constants for the multicycle control unit
package ctrl_pkg;

    localparam logic [4:0] OP_AR = 5'b00010;
    localparam logic [4:0] OP_I  = 5'b00001;
    localparam logic [4:0] OP_T  = 5'b01011;
    localparam logic [4:0] OP_J  = 5'b00011;
    localparam logic [4:0] OP_M  = 5'b00100;
    localparam logic [4:0] OP_L  = 5'b00000;
    localparam logic [4:0] OP_L2 = 5'b01100;
    localparam logic [4:0] OP_Q  = 5'b01000;
    localparam logic [4:0] OP_P  = 5'b00111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    typedef enum logic [2:0] {
        K_ILLEGAL,
        K_ALU,
        K_BRANCH,
        K_LOAD,
        K_STORE,
        K_PCONLY
    } instrKind_e;

    localparam int SEL_W = 7;

    // Loads and stores are mutually exclusive, so the memory-data and
    // write-data-A selects share the top bit of the bundle.
    localparam int muxWriteReg           = 0;
    localparam int muxWriteData          = 1;
    localparam int C_reg2_aluB_mux       = 2;
    localparam int C_offset              = 3;
    localparam int C_L_mux               = 4;
    localparam int C_sub_mAluInputB_L    = 5;
    localparam int C_mDataMemVsAluOutput = 6;
    localparam int C_mWwriteDataA        = 6;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_PASS = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;

    function automatic logic [SEL_W-1:0] selBit(input int idx);
        return SEL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode-to-control decode (instruction class, ALUop, sel bundle)
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW    = 5,
    parameter int ALUOPW = 4
) (
    input  logic [OPW-1:0]    opcode,
    output instrKind_e        kind,
    output logic [ALUOPW-1:0] aluOp,
    output logic [SEL_W-1:0]  selBundle
);

    logic [4:0] baseOp;
    logic       upperSet;

    assign baseOp = opcode[4:0];

    generate
        if (OPW > 5) begin : gUpper
            assign upperSet = |opcode[OPW-1:5];
        end else begin : gNoUpper
            assign upperSet = 1'b0;
        end
    endgenerate

    always_comb begin
        kind      = K_ILLEGAL;
        aluOp     = '0;
        selBundle = '0;
        if (!upperSet) begin
            case (baseOp)
                OP_AR: begin
                    kind      = K_ALU;
                    aluOp     = '1;
                    selBundle = selBit(muxWriteReg) | selBit(C_reg2_aluB_mux);
                end
                OP_I: begin
                    kind      = K_ALU;
                    aluOp     = '1;
                    selBundle = selBit(C_sub_mAluInputB_L);
                end
                OP_T: begin
                    kind      = K_ALU;
                    aluOp     = '1;
                    selBundle = selBit(muxWriteReg) | selBit(C_sub_mAluInputB_L);
                end
                OP_Q: begin
                    kind      = K_ALU;
                    aluOp     = ALUOPW'(ALU_PASS);
                    selBundle = selBit(muxWriteData);
                end
                OP_J: begin
                    kind      = K_BRANCH;
                    aluOp     = ALUOPW'(ALU_SUB);
                    selBundle = selBit(C_reg2_aluB_mux);
                end
                OP_M: begin
                    kind      = K_BRANCH;
                    aluOp     = ALUOPW'(ALU_SUB);
                    selBundle = selBit(C_reg2_aluB_mux) | selBit(C_offset);
                end
                OP_L: begin
                    kind      = K_LOAD;
                    aluOp     = ALUOPW'(ALU_ADD);
                    selBundle = selBit(C_L_mux) | selBit(C_sub_mAluInputB_L)
                              | selBit(C_mDataMemVsAluOutput);
                end
                OP_L2: begin
                    kind      = K_STORE;
                    aluOp     = ALUOPW'(ALU_ADD);
                    selBundle = selBit(C_sub_mAluInputB_L) | selBit(C_mWwriteDataA);
                end
                OP_P: begin
                    kind = K_PCONLY;
                end
                default: begin
                    kind = K_ILLEGAL;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - IDLE/DECODE/EXEC/MEM/WB control FSM with registered outputs
// Optional MEM wait timeout enabled by CTRL_MEM_TIMEOUT_EN.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPW     = 5,
    parameter int ALUOPW  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OPW-1:0]    opcode,
    input  logic              branchIdea,
    input  logic              mem_ack,
    output logic [ALUOPW-1:0] ALUop,
    output logic              regWrite,
    output logic [6:0]        sel,
    output logic              pcSrc,
    output logic              C_read_dm,
    output logic              C_write_dm,
    output logic              pc_en,
    output logic              illegal,
    output logic              mem_timeout
);

    generate
        if (OPW < 5) begin : gBadOpw
            $error("OPW must be at least 5");
        end
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : gBadTimeout
            $error("TIMEOUT must be in 1..255");
        end
    endgenerate

    state_e            state;
    instrKind_e        kindQ;
    logic              branchQ;
    instrKind_e        decKind;
    logic [ALUOPW-1:0] decAluOp;
    logic [SEL_W-1:0]  decSel;

`ifdef CTRL_MEM_TIMEOUT_EN
    logic [7:0] waitCnt;
`else
    assign mem_timeout = 1'b0;
`endif

    // Decode runs on the live opcode so DECODE-cycle pulses can be registered at accept.
    ctrl_decode #(
        .OPW    (OPW),
        .ALUOPW (ALUOPW)
    ) uDecode (
        .opcode    (opcode),
        .kind      (decKind),
        .aluOp     (decAluOp),
        .selBundle (decSel)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            kindQ       <= K_ILLEGAL;
            branchQ     <= 1'b0;
            instr_ready <= 1'b1;
            ALUop       <= '0;
            sel         <= '0;
            regWrite    <= 1'b0;
            pcSrc       <= 1'b0;
            C_read_dm   <= 1'b0;
            C_write_dm  <= 1'b0;
            pc_en       <= 1'b0;
            illegal     <= 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
            waitCnt     <= '0;
            mem_timeout <= 1'b0;
`endif
        end else begin
            regWrite <= 1'b0;
            pcSrc    <= 1'b0;
            pc_en    <= 1'b0;
            illegal  <= 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
            mem_timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        state       <= S_DECODE;
                        instr_ready <= 1'b0;
                        kindQ       <= decKind;
                        branchQ     <= branchIdea;
                        ALUop       <= decAluOp;
                        sel         <= decSel;
                        illegal     <= (decKind == K_ILLEGAL);
                        pc_en       <= (decKind == K_PCONLY);
                    end
                end
                S_DECODE: begin
                    if (kindQ == K_ILLEGAL || kindQ == K_PCONLY) begin
                        state       <= S_IDLE;
                        instr_ready <= 1'b1;
                        ALUop       <= '0;
                        sel         <= '0;
                    end else begin
                        state <= S_EXEC;
                        if (kindQ == K_ALU) begin
                            regWrite <= 1'b1;
                            pc_en    <= 1'b1;
                        end else if (kindQ == K_BRANCH) begin
                            pcSrc <= branchQ;
                            pc_en <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (kindQ == K_LOAD || kindQ == K_STORE) begin
                        state      <= S_MEM;
                        C_read_dm  <= (kindQ == K_LOAD);
                        C_write_dm <= (kindQ == K_STORE);
`ifdef CTRL_MEM_TIMEOUT_EN
                        waitCnt    <= '0;
`endif
                    end else begin
                        state       <= S_IDLE;
                        instr_ready <= 1'b1;
                        ALUop       <= '0;
                        sel         <= '0;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        C_read_dm  <= 1'b0;
                        C_write_dm <= 1'b0;
                        pc_en      <= 1'b1;
                        if (kindQ == K_LOAD) begin
                            state    <= S_WB;
                            regWrite <= 1'b1;
                        end else begin
                            state       <= S_IDLE;
                            instr_ready <= 1'b1;
                            ALUop       <= '0;
                            sel         <= '0;
                        end
                    end
`ifdef CTRL_MEM_TIMEOUT_EN
                    else if (waitCnt == 8'(TIMEOUT - 1)) begin
                        C_read_dm   <= 1'b0;
                        C_write_dm  <= 1'b0;
                        mem_timeout <= 1'b1;
                        state       <= S_IDLE;
                        instr_ready <= 1'b1;
                        ALUop       <= '0;
                        sel         <= '0;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
`endif
                end
                S_WB: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                    ALUop       <= '0;
                    sel         <= '0;
                end
                default: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                    C_read_dm   <= 1'b0;
                    C_write_dm  <= 1'b0;
                    ALUop       <= '0;
                    sel         <= '0;
                end
            endcase
        end
    end

endmodule
